msx_reload_sequencer: RTL and testbench

- Sits directly downstream of the MSX configuration block and consumes its reload request and the slot A SRAM size selection.
- Turns a configuration change into an ordered restart:
  - holds the MSX core in reset;
  - waits for any HPS ROM download to finish;
  - zero-fills the cartridge SRAM region through a request/acknowledge write port;
  - releases reset after a fixed hold time.
- A user reset performs the same sequence without the SRAM clear.

---
 rtl/msx_reload_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_msx_reload_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/msx_reload_sequencer.sv
// msx_reload_sequencer
//   Turns a configuration change into an ordered MSX restart. The core is held
//   in reset, the sequencer waits for any HPS ROM download to finish, then
//   zero-fills the cartridge SRAM through a req/ack port. Reset is released
//   after HOLD_CYCLES cycles. A user reset runs the same sequence but skips
//   the SRAM clear.
// Ports:
//   clk, reset        system clock; asynchronous active-high reset
//   reload            level; configuration changed (restart with SRAM clear)
//   user_reset        level; restart without SRAM clear
//   ioctl_download    high while the HPS is loading a ROM image
//   sram_size         slot A SRAM size in kB (0 or a power of two, 1..128)
//   clr_ack           one-cycle acknowledge of the current clear write
//   msx_reset         reset to the MSX core (registered)
//   clr_req/clr_addr  SRAM clear write request and byte address (data is 0x00)
//   busy              high in any state other than RUN
//   cart_reinit       one-cycle pulse on the first RUN cycle after a sequence
module msx_reload_sequencer #(
   parameter int HOLD_CYCLES = 1024,
   parameter int SRAM_AW     = 17
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               reload,
   input  logic               user_reset,
   input  logic               ioctl_download,
   input  logic [7:0]         sram_size,
   input  logic               clr_ack,
   output logic               msx_reset,
   output logic               clr_req,
   output logic [SRAM_AW-1:0] clr_addr,
   output logic               busy,
   output logic               cart_reinit
);

   localparam int HCW = $clog2(HOLD_CYCLES + 1);
   localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {RUN, WAIT_DL, CLEAR, HOLD} state_t;

   state_t             state_q, state_d;
   logic [HCW-1:0]     hold_cnt_q, hold_cnt_d;
   logic               clear_pending_q, clear_pending_d;
   logic               restart_pending_q, restart_pending_d;
   logic [SRAM_AW-1:0] clr_last_q, clr_last_d;
   logic [SRAM_AW-1:0] clr_addr_q, clr_addr_d;
   logic               clr_req_q, clr_req_d;
   logic               msx_reset_q, msx_reset_d;
   logic               busy_q, busy_d;
   logic               cart_reinit_q, cart_reinit_d;
   logic               reload_prev_q, reload_prev_d;
   logic               user_prev_q, user_prev_d;

   logic        reload_rise, user_rise, retrig, ack;
   logic [31:0] size_bytes;

   always_comb begin
      reload_rise = reload & ~reload_prev_q;
      user_rise   = user_reset & ~user_prev_q;
      retrig      = reload_rise | user_rise;
      // an ack only counts while a write is actually outstanding
      ack         = clr_ack & clr_req_q;
      size_bytes  = {14'd0, sram_size, 10'd0};

      state_d           = state_q;
      hold_cnt_d        = hold_cnt_q;
      clear_pending_d   = clear_pending_q;
      restart_pending_d = restart_pending_q;
      clr_last_d        = clr_last_q;
      clr_addr_d        = clr_addr_q;
      clr_req_d         = clr_req_q;
      cart_reinit_d     = 1'b0;
      reload_prev_d     = reload;
      user_prev_d       = user_reset;

      case (state_q)
         RUN: begin
            // level sensitive here, so a request held across RUN entry still restarts
            hold_cnt_d = '0;
            if (reload) begin
               clear_pending_d = 1'b1;
               state_d         = WAIT_DL;
            end else if (user_reset) begin
               state_d = WAIT_DL;
            end
         end
         WAIT_DL: begin
            if (retrig) begin
               hold_cnt_d = '0;
               if (reload_rise) clear_pending_d = 1'b1;
            end else if (!ioctl_download) begin
               if (clear_pending_q && sram_size != 8'd0) begin
                  state_d    = CLEAR;
                  clr_last_d = SRAM_AW'(size_bytes - 32'd1);
                  clr_addr_d = '0;
                  clr_req_d  = 1'b1;
               end else begin
                  state_d         = HOLD;
                  hold_cnt_d      = '0;
                  clear_pending_d = 1'b0;
               end
            end
         end
         CLEAR: begin
            // a retrigger never abandons the in-flight write; it is honoured on its ack
            if (reload_rise) clear_pending_d = 1'b1;
            if (retrig) restart_pending_d = 1'b1;
            if (ack) begin
               if (restart_pending_q || retrig) begin
                  state_d           = WAIT_DL;
                  clr_req_d         = 1'b0;
                  clr_addr_d        = '0;
                  restart_pending_d = 1'b0;
                  hold_cnt_d        = '0;
               end else if (clr_addr_q == clr_last_q) begin
                  state_d         = HOLD;
                  clr_req_d       = 1'b0;
                  clr_addr_d      = '0;
                  clear_pending_d = 1'b0;
                  hold_cnt_d      = '0;
               end else begin
                  clr_addr_d = clr_addr_q + 1'b1;
               end
            end
         end
         HOLD: begin
            if (retrig) begin
               state_d    = WAIT_DL;
               hold_cnt_d = '0;
               if (reload_rise) clear_pending_d = 1'b1;
            end else if (hold_cnt_q == HOLD_LAST) begin
               state_d       = RUN;
               hold_cnt_d    = '0;
               cart_reinit_d = 1'b1;
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         default: state_d = WAIT_DL;
      endcase

      // outputs are registered from the next state
      msx_reset_d = (state_d != RUN);
      busy_d      = (state_d != RUN);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q           <= WAIT_DL;
         hold_cnt_q        <= '0;
         clear_pending_q   <= 1'b0;
         restart_pending_q <= 1'b0;
         clr_last_q        <= '0;
         clr_addr_q        <= '0;
         clr_req_q         <= 1'b0;
         msx_reset_q       <= 1'b1;
         busy_q            <= 1'b1;
         cart_reinit_q     <= 1'b0;
         // reset high so a level already present at reset release is not an edge
         reload_prev_q     <= 1'b1;
         user_prev_q       <= 1'b1;
      end else begin
         state_q           <= state_d;
         hold_cnt_q        <= hold_cnt_d;
         clear_pending_q   <= clear_pending_d;
         restart_pending_q <= restart_pending_d;
         clr_last_q        <= clr_last_d;
         clr_addr_q        <= clr_addr_d;
         clr_req_q         <= clr_req_d;
         msx_reset_q       <= msx_reset_d;
         busy_q            <= busy_d;
         cart_reinit_q     <= cart_reinit_d;
         reload_prev_q     <= reload_prev_d;
         user_prev_q       <= user_prev_d;
      end
   end

   assign msx_reset   = msx_reset_q;
   assign clr_req     = clr_req_q;
   assign clr_addr    = clr_addr_q;
   assign busy        = busy_q;
   assign cart_reinit = cart_reinit_q;

endmodule

// File: tb/tb_msx_reload_sequencer.sv
module tb_msx_reload_sequencer;
   localparam int HOLD = 8;
   localparam int AW   = 17;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          reload = 1'b0, user_reset = 1'b0, ioctl_download = 1'b0;
   logic [7:0]    sram_size = 8'd0;
   logic          clr_ack = 1'b0;
   logic          msx_reset, clr_req, busy, cart_reinit;
   logic [AW-1:0] clr_addr;

   msx_reload_sequencer #(.HOLD_CYCLES(HOLD), .SRAM_AW(AW)) dut (
      .clk(clk), .reset(reset), .reload(reload), .user_reset(user_reset),
      .ioctl_download(ioctl_download), .sram_size(sram_size), .clr_ack(clr_ack),
      .msx_reset(msx_reset), .clr_req(clr_req), .clr_addr(clr_addr),
      .busy(busy), .cart_reinit(cart_reinit)
   );

   always #5 clk = ~clk;

   int            n_cmp = 0, n_err = 0, n_wr = 0;
   logic [AW-1:0] exp_q[$];
   logic          blk_en = 1'b0;
   logic [AW-1:0] blk_addr = '0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h @%0t", tag, act, exp, $time);
      end
   endtask

   task automatic push_range(input int lo, input int hi);
      for (int a = lo; a <= hi; a++) exp_q.push_back(AW'(a));
   endtask

   // SRAM responder: acks every 2nd cycle, scoreboards each accepted write
   // and checks the request stays put while no ack is given.
   initial begin : responder
      logic          prev_req = 1'b0, prev_ack = 1'b0;
      logic [AW-1:0] prev_addr = '0;
      forever begin
         @(negedge clk);
         if (prev_req && !prev_ack && clr_req)
            chk("addr_hold", 32'(clr_addr), 32'(prev_addr));
         if (clr_ack) clr_ack = 1'b0;
         else if (!reset && clr_req && !(blk_en && clr_addr == blk_addr)) begin
            if (exp_q.size() == 0) chk("sb_extra", 32'(exp_q.size()), 32'd1);
            else chk("sb_addr", 32'(clr_addr), 32'(exp_q.pop_front()));
            n_wr++;
            clr_ack = 1'b1;
         end
         prev_req  = clr_req;
         prev_addr = clr_addr;
         prev_ack  = clr_ack;
      end
   end

   // Runs until busy drops, counting msx_reset / clr_req cycles and reinit pulses.
   task automatic wait_run(output int rst_c, output int pulses, output int reqs);
      rst_c = 0; pulses = 0; reqs = 0;
      for (int k = 0; k < 20000; k++) begin
         @(negedge clk);
         if (msx_reset) rst_c++;
         if (cart_reinit) pulses++;
         if (clr_req) reqs++;
         reload = 1'b0;
         user_reset = 1'b0;
         if (!busy) break;
      end
      chk("run_tmo", 32'(busy), 32'd0);
      @(negedge clk);
      if (cart_reinit) pulses++;
   endtask

   task automatic wait_addr(input logic [AW-1:0] a);
      for (int k = 0; k < 20000 && !(clr_req && clr_addr == a); k++) @(negedge clk);
      chk("wait_addr", 32'(clr_addr), 32'(a));
   endtask

   initial begin
      int rc, pc, qc, bc;
      repeat (3) @(negedge clk);
      chk("rst_msx", 32'(msx_reset), 32'd1);
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_req", 32'(clr_req), 32'd0);
      chk("rst_addr", 32'(clr_addr), 32'd0);
      chk("rst_reinit", 32'(cart_reinit), 32'd0);
      reset = 1'b0;

      // power-up: WAIT_DL -> HOLD(8) -> RUN, no clear
      wait_run(rc, pc, qc);
      chk("pu_rst", rc, HOLD);
      chk("pu_pulse", pc, 1);
      chk("pu_req", qc, 0);

      // reload, 2 kB: 2048 writes; size change mid-clear is ignored
      sram_size = 8'd2;
      n_wr = 0;
      push_range(0, 'h7FF);
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
      wait_addr(AW'(1));
      sram_size = 8'd1;
      wait_run(rc, pc, qc);
      chk("rl_writes", n_wr, 2048);
      chk("rl_q", 32'(exp_q.size()), 0);
      chk("rl_pulse", pc, 1);
      chk("rl_msx", 32'(msx_reset), 0);

      // download gating
      sram_size = 8'd1;
      push_range(0, 'h3FF);
      ioctl_download = 1'b1;
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
      qc = 0; bc = 0;
      repeat (100) begin
         @(negedge clk);
         if (clr_req) qc++;
         if (busy && msx_reset) bc++;
      end
      chk("dl_req", qc, 0);
      chk("dl_busy", bc, 100);
      ioctl_download = 1'b0;
      wait_run(rc, pc, qc);
      chk("dl_q", 32'(exp_q.size()), 0);
      chk("dl_pulse", pc, 1);

      // user reset: no clear, 1 + HOLD cycles in reset
      sram_size = 8'd32;
      user_reset = 1'b1;
      wait_run(rc, pc, qc);
      chk("ur_rst", rc, 1 + HOLD);
      chk("ur_req", qc, 0);
      chk("ur_pulse", pc, 1);

      // retrigger mid-clear with the ack withheld
      sram_size = 8'd1;
      blk_en = 1'b1;
      blk_addr = AW'('h10);
      push_range(0, 'h10);
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
      wait_addr(AW'('h10));
      repeat (5) @(negedge clk);
      chk("wd_req", 32'(clr_req), 1);
      chk("wd_addr", 32'(clr_addr), 'h10);
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
      repeat (3) @(negedge clk);
      chk("rt_req", 32'(clr_req), 1);
      chk("rt_addr", 32'(clr_addr), 'h10);
      push_range(0, 'h3FF);
      blk_en = 1'b0;
      wait_run(rc, pc, qc);
      chk("rt_q", 32'(exp_q.size()), 0);
      chk("rt_pulse", pc, 1);

      // async reset mid-clear
      blk_en = 1'b1;
      blk_addr = AW'('h123);
      push_range(0, 'h122);
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
      wait_addr(AW'('h123));
      #2 reset = 1'b1;
      #1;
      chk("ar_req", 32'(clr_req), 0);
      chk("ar_addr", 32'(clr_addr), 0);
      chk("ar_msx", 32'(msx_reset), 1);
      chk("ar_busy", 32'(busy), 1);
      @(negedge clk);
      blk_en = 1'b0;
      reset = 1'b0;
      wait_run(rc, pc, qc);
      chk("ar_rst", rc, HOLD);
      chk("ar_noclr", qc, 0);
      chk("ar_pulse", pc, 1);
      chk("ar_q", 32'(exp_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
